// File: rtl/psec5_readout_serializer_if.sv
// Readout bus between the PSEC5 channel readout serializer and its consumer.
// Carries the command/abort inputs, the flattened CTMP snapshots and the serial outputs.
interface psec5_readout_serializer_if #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned WORD_W = 56
);
    logic                       INST_READOUT;
    logic                       ABORT;
    logic [NUM_CH*WORD_W-1:0]   CTMP;
    logic                       SDO;
    logic                       SDO_VALID;
    logic                       FRAME;
    logic [3:0]                 CH_SEL;
    logic                       BUSY;
    logic                       DONE;

    modport master (
        output INST_READOUT, ABORT, CTMP,
        input  SDO, SDO_VALID, FRAME, CH_SEL, BUSY, DONE
    );

    modport slave (
        input  INST_READOUT, ABORT, CTMP,
        output SDO, SDO_VALID, FRAME, CH_SEL, BUSY, DONE
    );
endinterface

// File: rtl/psec5_readout_serializer.sv
// Snapshots all channel CTMP words on a readout command and shifts them out
// MSB-first as {1010, ch, data, even parity} words separated by one gap cycle.
module psec5_readout_serializer #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned WORD_W = 56
) (
    input  logic SPI_CLK,
    input  logic RST,
    psec5_readout_serializer_if.slave bus
);
    localparam int unsigned HDR_W = 8;
    localparam int unsigned FRM_W = HDR_W + WORD_W + 1;
    localparam int unsigned BIT_W = 7;
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRM_W - 1);
    localparam logic [3:0]       LAST_CH  = 4'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_END
    } state_t;

    state_t                           state;
    logic                             rd_q;
    logic [NUM_CH-1:0][WORD_W-1:0]    shadow;
    logic [NUM_CH-1:0][WORD_W-1:0]    ctmp_arr;
    logic [FRM_W-1:0]                 sreg;
    logic [BIT_W-1:0]                 bit_cnt;
    logic [3:0]                       ch_idx;
    logic [IDX_W-1:0]                 nxt_idx;

    logic                             sdo_q;
    logic                             sdo_valid_q;
    logic                             frame_q;
    logic [3:0]                       ch_sel_q;
    logic                             busy_q;
    logic                             done_q;

    function automatic logic [FRM_W-1:0] frame_word(input logic [3:0] ch,
                                                    input logic [WORD_W-1:0] data);
        return {4'b1010, ch, data, ^data};
    endfunction

    assign ctmp_arr = bus.CTMP;
    assign nxt_idx  = IDX_W'(ch_idx + 4'd1);

    // Outputs are registered from the current state, so they trail it by one cycle;
    // abort and reset clear them directly so they drop on the very next edge.
    always_ff @(posedge SPI_CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            rd_q        <= 1'b0;
            shadow      <= '0;
            sreg        <= '0;
            bit_cnt     <= '0;
            ch_idx      <= '0;
            sdo_q       <= 1'b0;
            sdo_valid_q <= 1'b0;
            frame_q     <= 1'b0;
            ch_sel_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_q        <= bus.INST_READOUT;
            sdo_q       <= (state == ST_SHIFT) & sreg[FRM_W-1];
            sdo_valid_q <= (state == ST_SHIFT);
            frame_q     <= (state == ST_SHIFT) || (state == ST_GAP);
            ch_sel_q    <= ch_idx;
            busy_q      <= (state != ST_IDLE);
            done_q      <= (state == ST_END);

            if (bus.ABORT && (state != ST_IDLE)) begin
                state       <= ST_IDLE;
                sreg        <= '0;
                bit_cnt     <= '0;
                ch_idx      <= '0;
                sdo_q       <= 1'b0;
                sdo_valid_q <= 1'b0;
                frame_q     <= 1'b0;
                ch_sel_q    <= '0;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.INST_READOUT && !rd_q && !bus.ABORT) begin
                            shadow  <= ctmp_arr;
                            sreg    <= frame_word(4'd0, ctmp_arr[0]);
                            ch_idx  <= '0;
                            bit_cnt <= '0;
                            state   <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        sreg <= {sreg[FRM_W-2:0], 1'b0};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= (ch_idx == LAST_CH) ? ST_END : ST_GAP;
                        end else begin
                            bit_cnt <= bit_cnt + 7'd1;
                        end
                    end
                    ST_GAP: begin
                        ch_idx <= ch_idx + 4'd1;
                        sreg   <= frame_word(ch_idx + 4'd1, shadow[nxt_idx]);
                        state  <= ST_SHIFT;
                    end
                    ST_END: begin
                        ch_idx <= '0;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.SDO       = sdo_q;
    assign bus.SDO_VALID = sdo_valid_q;
    assign bus.FRAME     = frame_q;
    assign bus.CH_SEL    = ch_sel_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
endmodule

// File: tb/tb_psec5_readout_serializer.sv
// Directed bench for psec5_readout_serializer: one-channel and two-channel instances,
// expected serial bits queued at each start and popped as the frame comes out.
module tb_psec5_readout_serializer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psec5_readout_serializer_if #(.NUM_CH(1), .WORD_W(56)) if1 ();
    psec5_readout_serializer_if #(.NUM_CH(2), .WORD_W(56)) if2 ();

    psec5_readout_serializer #(.NUM_CH(1), .WORD_W(56)) dut1 (
        .SPI_CLK (clk),
        .RST     (rst),
        .bus     (if1.slave)
    );

    psec5_readout_serializer #(.NUM_CH(2), .WORD_W(56)) dut2 (
        .SPI_CLK (clk),
        .RST     (rst),
        .bus     (if2.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        sel;
    logic [55:0] c0, c1;
    bit          exp_q[$];
    logic [8:0]  mon;

    // {SDO, SDO_VALID, FRAME, BUSY, DONE, CH_SEL} of the selected instance
    always_comb begin
        mon = sel ? {if2.SDO, if2.SDO_VALID, if2.FRAME, if2.BUSY, if2.DONE, if2.CH_SEL}
                  : {if1.SDO, if1.SDO_VALID, if1.FRAME, if1.BUSY, if1.DONE, if1.CH_SEL};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] word(input logic [3:0] ch, input logic [55:0] d);
        return {4'b1010, ch, d, ^d};
    endfunction

    task automatic drive_inputs(input logic rd, input logic ab);
        if (sel) begin
            if2.INST_READOUT = rd;
            if2.ABORT        = ab;
            if2.CTMP         = {c1, c0};
        end else begin
            if1.INST_READOUT = rd;
            if1.ABORT        = ab;
            if1.CTMP         = c0;
        end
    endtask

    // Queue the expected frame, raise INST_READOUT, return just after start edge k.
    task automatic start(input bit hold);
        logic [64:0] w;
        int nch;
        nch = sel ? 2 : 1;
        exp_q.delete();
        for (int j = 0; j < nch; j++) begin
            w = word(4'(j), (j == 0) ? c0 : c1);
            for (int b = 64; b >= 0; b--) exp_q.push_back(w[b]);
        end
        drive_inputs(1'b1, 1'b0);
        step();
        if (!hold) drive_inputs(1'b0, 1'b0);
    endtask

    // Check cycles k+1 .. k+66*nch; optionally abort after bit abort_at of ch0.
    task automatic check_frame(input string tag, input int abort_at);
        int nch, pos, ch;
        logic [8:0] exp, mask;
        bit b;
        nch = sel ? 2 : 1;
        for (int i = 1; i <= 66 * nch; i++) begin
            step();
            pos  = (i - 1) % 66;
            ch   = (i - 1) / 66;
            mask = 9'h1FF;
            if (i == 66 * nch) begin
                exp  = {5'b00011, 4'd0};
                mask = 9'h1F0;
            end else if (pos == 65) begin
                exp  = {5'b00110, 4'd0};
                mask = 9'h1F0;
            end else begin
                b   = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b0;
                exp = {b, 4'b1110, 4'(ch)};
            end
            chk($sformatf("%s_cyc%0d", tag, i), 64'(mon & mask), 64'(exp & mask));
            if (i - 1 == abort_at) begin
                drive_inputs(1'b0, 1'b1);
                step();
                chk($sformatf("%s_abort_outs", tag), 64'(mon), 64'd0);
                drive_inputs(1'b0, 1'b0);
                exp_q.delete();
                return;
            end
        end
        chk($sformatf("%s_queue_empty", tag), 64'(exp_q.size()), 64'd0);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s_idle%0d", tag, i), 64'(mon), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        c0  = '0;
        c1  = '0;
        sel = 1'b0; drive_inputs(1'b0, 1'b0);
        sel = 1'b1; drive_inputs(1'b0, 1'b0);
        repeat (3) step();
        sel = 1'b0; chk("reset_dut1", 64'(mon), 64'd0);
        sel = 1'b1; chk("reset_dut2", 64'(mon), 64'd0);
        rst = 1'b0;
        idle_check("post_reset", 2);

        // single channel, then an immediate restart in the cycle after DONE
        sel = 1'b0;
        c0  = 56'h00_0000_0000_0001;
        start(1'b0);
        check_frame("one_ch", -1);
        c0  = 56'({$urandom(), $urandom()});
        start(1'b0);
        check_frame("one_ch_b2b", -1);
        idle_check("one_ch_end", 3);

        // two channels with the gap between them
        sel = 1'b1;
        c0  = 56'h00_03FF_0000_0000;
        c1  = 56'h00_0000_0000_0000;
        start(1'b0);
        check_frame("two_ch", -1);
        idle_check("two_ch_end", 2);

        // CTMP changes right after the start edge must not leak into the frame
        c0 = 56'({$urandom(), $urandom()});
        c1 = 56'({$urandom(), $urandom()});
        start(1'b0);
        c0 = ~c0;
        c1 = c1 ^ 56'h5A_5A5A_5A5A_5A5A;
        drive_inputs(1'b0, 1'b0);
        check_frame("snapshot", -1);
        idle_check("snapshot_end", 2);

        // held command gives one frame; a new rising edge is needed for the next
        c0 = 56'({$urandom(), $urandom()});
        c1 = 56'({$urandom(), $urandom()});
        start(1'b1);
        check_frame("hold", -1);
        idle_check("hold_high", 10);
        drive_inputs(1'b0, 1'b0);
        idle_check("hold_low", 1);
        c0 = 56'hFF_FFFF_FFFF_FFFF;
        start(1'b0);
        check_frame("retrig", -1);
        idle_check("retrig_end", 2);

        // abort at bit 20 of channel 0, then a clean full frame
        c0 = 56'({$urandom(), $urandom()});
        start(1'b0);
        check_frame("abort", 20);
        idle_check("abort_quiet", 140);
        c1 = 56'({$urandom(), $urandom()});
        start(1'b0);
        check_frame("after_abort", -1);
        idle_check("after_abort_end", 2);

        // reset in mid-frame
        start(1'b0);
        repeat (30) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mid_rst%0d", i), 64'(mon), 64'd0);
        end
        rst = 1'b0;
        exp_q.delete();
        idle_check("rst_release", 5);
        sel = 1'b0;
        chk("rst_release_dut1", 64'(mon), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
